// File: rtl/systolic_tile_addr_gen_pkg.sv
// Shared types and helpers for the systolic tile address sequencer.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Field width for a value range of n; degenerate ranges keep a 1-bit field held at 0.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/systolic_tile_addr_gen_wrap_counter.sv
// Modulo-MAX counter: advances on i_en, wraps to 0 after MAX-1.
// o_next is the value the counter takes at the coming edge, so the parent can
// register derived quantities (addresses) in step with the count.
module wrap_counter
    import systolic_pkg::*;
#(
    parameter int  MAX = 2,
    localparam int W   = clog2_min1(MAX)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_value,
    output logic [W-1:0] o_next,
    output logic         o_wrap
);

    logic [W-1:0] r_value;
    logic         w_at_max;

    assign w_at_max = (r_value == W'(MAX - 1));
    assign o_wrap   = i_en && w_at_max;
    assign o_next   = !i_en ? r_value : (w_at_max ? '0 : r_value + W'(1));
    assign o_value  = r_value;

    // Count register; reset returns to 0 immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_value <= '0;
        end else begin
            r_value <= o_next;
        end
    end

endmodule

// File: rtl/systolic_tile_addr_gen.sv
// Operand-buffer address sequencer for an N1xN2 output-stationary systolic array.
// Walks all (A row-slice, B col-slice) tiles of C = A*B, streaming K_DIM addresses
// into the A and B buffers per tile, with an optional drain gap after each tile.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start
// STREAM | issuing one A/B address pair per unstalled cycle
// DRAIN  | rd_en low for DRAIN cycles while the array flushes a tile
// DONE   | one-cycle done pulse, then back to IDLE
module systolic_tile_addr_gen
    import systolic_pkg::*;
#(
    parameter int  N1      = 4,
    parameter int  N2      = 4,
    parameter int  M_DIM   = 8,
    parameter int  K_DIM   = 8,
    parameter int  P_DIM   = 8,
    parameter int  DRAIN   = 6,
    parameter int  A_OUTER = 1,
    localparam int SA_N    = M_DIM / N1,
    localparam int SB_N    = P_DIM / N2,
    localparam int AW      = clog2_min1(SA_N * K_DIM),
    localparam int BW      = clog2_min1(SB_N * K_DIM),
    localparam int KW      = clog2_min1(K_DIM),
    localparam int SAW     = clog2_min1(SA_N),
    localparam int SBW     = clog2_min1(SB_N),
    localparam int DW      = clog2_min1((DRAIN > 0) ? DRAIN : 1)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic           i_stall,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_rd_en,
    output logic [AW-1:0]  o_rd_addr_a,
    output logic [BW-1:0]  o_rd_addr_b,
    output logic [KW-1:0]  o_k_cntr,
    output logic [SAW-1:0] o_slice_a,
    output logic [SBW-1:0] o_slice_b,
    output logic           o_first_k,
    output logic           o_last_k,
    output logic           o_tile_done
);

    state_t         r_state;
    logic           r_busy;
    logic           r_done;
    logic           r_rd_en;
    logic           r_first_k;
    logic           r_last_k;
    logic           r_tile_done;
    logic [AW-1:0]  r_rd_addr_a;
    logic [BW-1:0]  r_rd_addr_b;

    logic           w_k_en;
    logic           w_k_wrap;
    logic [KW-1:0]  w_k_val;
    logic [KW-1:0]  w_k_nxt;
    logic           w_sa_en;
    logic           w_sa_wrap;
    logic [SAW-1:0] w_sa_val;
    logic [SAW-1:0] w_sa_nxt;
    logic           w_sb_en;
    logic           w_sb_wrap;
    logic [SBW-1:0] w_sb_val;
    logic [SBW-1:0] w_sb_nxt;
    logic           w_dr_en;
    logic           w_dr_wrap;
    logic [DW-1:0]  w_dr_val;
    logic [DW-1:0]  w_dr_nxt;
    logic           w_tile_end;
    logic           w_last_tile;
    logic           w_first_nxt;
    logic           w_last_nxt;
    logic [AW-1:0]  w_addr_a_nxt;
    logic [BW-1:0]  w_addr_b_nxt;
    logic           w_unused_drain;

    // Stall freezes every counter; the drain counter only runs when a gap exists.
    assign w_k_en     = (r_state == ST_STREAM) && !i_stall;
    assign w_dr_en    = (DRAIN > 0) && (r_state == ST_DRAIN) && !i_stall;
    assign w_tile_end = (DRAIN > 0) ? w_dr_wrap : w_k_wrap;

    // Inner slice steps once per tile; outer steps when inner wraps.
    // The outer wrap marks the final (outer, inner) pair.
    generate
        if (A_OUTER != 0) begin : g_a_outer
            assign w_sb_en     = w_tile_end;
            assign w_sa_en     = w_sb_wrap;
            assign w_last_tile = w_sa_wrap;
        end else begin : g_b_outer
            assign w_sa_en     = w_tile_end;
            assign w_sb_en     = w_sa_wrap;
            assign w_last_tile = w_sb_wrap;
        end
    endgenerate

    wrap_counter #(.MAX(K_DIM)) u_k_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_k_en),
        .o_value (w_k_val),
        .o_next  (w_k_nxt),
        .o_wrap  (w_k_wrap)
    );

    wrap_counter #(.MAX(SA_N)) u_sa_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_sa_en),
        .o_value (w_sa_val),
        .o_next  (w_sa_nxt),
        .o_wrap  (w_sa_wrap)
    );

    wrap_counter #(.MAX(SB_N)) u_sb_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_sb_en),
        .o_value (w_sb_val),
        .o_next  (w_sb_nxt),
        .o_wrap  (w_sb_wrap)
    );

    wrap_counter #(.MAX((DRAIN > 0) ? DRAIN : 1)) u_drain_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_dr_en),
        .o_value (w_dr_val),
        .o_next  (w_dr_nxt),
        .o_wrap  (w_dr_wrap)
    );

    // Only the drain wrap matters; its count value is internal.
    assign w_unused_drain = ^{w_dr_val, w_dr_nxt};

    // Every counter returns to 0 by the end of a full multiply, so IDLE needs no clear.
    assign w_first_nxt  = (w_k_nxt == '0);
    assign w_last_nxt   = (w_k_nxt == KW'(K_DIM - 1));
    assign w_addr_a_nxt = AW'(w_sa_nxt) * AW'(K_DIM) + AW'(w_k_nxt);
    assign w_addr_b_nxt = BW'(w_sb_nxt) * BW'(K_DIM) + BW'(w_k_nxt);

    // Sequencing FSM with registered handshake, strobes and addresses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_first_k   <= 1'b0;
            r_last_k    <= 1'b0;
            r_tile_done <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
        end else begin
            r_rd_addr_a <= w_addr_a_nxt;
            r_rd_addr_b <= w_addr_b_nxt;
            r_done      <= 1'b0;
            r_tile_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state   <= ST_STREAM;
                        r_busy    <= 1'b1;
                        r_rd_en   <= 1'b1;
                        r_first_k <= w_first_nxt;
                        r_last_k  <= w_last_nxt;
                    end
                end
                ST_STREAM: begin
                    if (i_stall) begin
                        r_rd_en   <= 1'b0;
                        r_first_k <= 1'b0;
                        r_last_k  <= 1'b0;
                    end else if (w_k_wrap && (DRAIN > 0)) begin
                        r_state   <= ST_DRAIN;
                        r_rd_en   <= 1'b0;
                        r_first_k <= 1'b0;
                        r_last_k  <= 1'b0;
                    end else if (w_k_wrap && w_last_tile) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_tile_done <= 1'b1;
                        r_rd_en     <= 1'b0;
                        r_first_k   <= 1'b0;
                        r_last_k    <= 1'b0;
                    end else begin
                        // Back-to-back tiles (no drain) report completion alongside the next k=0.
                        r_rd_en     <= 1'b1;
                        r_first_k   <= w_first_nxt;
                        r_last_k    <= w_last_nxt;
                        r_tile_done <= w_k_wrap;
                    end
                end
                ST_DRAIN: begin
                    if (w_dr_wrap) begin
                        r_tile_done <= 1'b1;
                        if (w_last_tile) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_STREAM;
                            r_rd_en   <= 1'b1;
                            r_first_k <= w_first_nxt;
                            r_last_k  <= w_last_nxt;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_rd_en     = r_rd_en;
    assign o_rd_addr_a = r_rd_addr_a;
    assign o_rd_addr_b = r_rd_addr_b;
    assign o_k_cntr    = w_k_val;
    assign o_slice_a   = w_sa_val;
    assign o_slice_b   = w_sb_val;
    assign o_first_k   = r_first_k;
    assign o_last_k    = r_last_k;
    assign o_tile_done = r_tile_done;

endmodule

// File: tb/tb_systolic_tile_addr_gen.sv
// Self-checking bench: several parameter sets run in parallel under random
// start/stall/reset stimulus, each compared cycle by cycle with a reference
// model that derives every output from the count of unstalled busy cycles.
module tb_systolic_tile_addr_gen;
    import systolic_pkg::*;

    localparam int NCFG = 5;
    localparam int NCYC = 1500;
    //                             cfg0 cfg1 cfg2 cfg3 cfg4
    localparam int CFG_N1 [NCFG] = '{4,   4,   4,   4,   2};
    localparam int CFG_N2 [NCFG] = '{4,   4,   4,   4,   4};
    localparam int CFG_M  [NCFG] = '{8,   8,   8,   4,   6};
    localparam int CFG_K  [NCFG] = '{8,   4,   3,   5,   1};
    localparam int CFG_P  [NCFG] = '{8,   8,   8,   12,  4};
    localparam int CFG_D  [NCFG] = '{6,   0,   2,   6,   1};
    localparam int CFG_AO [NCFG] = '{1,   1,   0,   1,   0};

    logic clk;
    int   n_chk      = 0;
    int   n_pass     = 0;
    int   n_cfg_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int K    = CFG_K[g];
        localparam int D    = CFG_D[g];
        localparam int SA_N = CFG_M[g] / CFG_N1[g];
        localparam int SB_N = CFG_P[g] / CFG_N2[g];
        localparam int KD   = K + D;
        localparam int T    = SA_N * SB_N * KD;
        localparam int AW   = clog2_min1(SA_N * K);
        localparam int BW   = clog2_min1(SB_N * K);
        localparam int KW   = clog2_min1(K);
        localparam int SAW  = clog2_min1(SA_N);
        localparam int SBW  = clog2_min1(SB_N);

        logic           rst_n, start, stall;
        logic           busy, done, rd_en, first_k, last_k, tile_done;
        logic [AW-1:0]  addr_a;
        logic [BW-1:0]  addr_b;
        logic [KW-1:0]  k_cntr;
        logic [SAW-1:0] slice_a;
        logic [SBW-1:0] slice_b;

        systolic_tile_addr_gen #(
            .N1(CFG_N1[g]), .N2(CFG_N2[g]), .M_DIM(CFG_M[g]), .K_DIM(K),
            .P_DIM(CFG_P[g]), .DRAIN(D), .A_OUTER(CFG_AO[g])
        ) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_start     (start),
            .i_stall     (stall),
            .o_busy      (busy),
            .o_done      (done),
            .o_rd_en     (rd_en),
            .o_rd_addr_a (addr_a),
            .o_rd_addr_b (addr_b),
            .o_k_cntr    (k_cntr),
            .o_slice_a   (slice_a),
            .o_slice_b   (slice_b),
            .o_first_k   (first_k),
            .o_last_k    (last_k),
            .o_tile_done (tile_done)
        );

        // Model: phase 0 idle, 1 busy, 2 done cycle; ub = unstalled busy edges since start.
        int   phase, ub, pos, t, sa, sb, n_done;
        logic pbusy, exp_rd, exp_td;

        function automatic logic any_out();
            return |{busy, done, rd_en, addr_a, addr_b, k_cntr, slice_a, slice_b,
                     first_k, last_k, tile_done};
        endfunction

        initial begin
            rst_n = 1'b0; start = 1'b0; stall = 1'b0;
            phase = 0; ub = 0; n_done = 0;
            @(negedge clk);
            chk($sformatf("c%0d reset_zero", g), 32'(any_out()), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int cyc = 0; cyc < NCYC; cyc++) begin
                @(negedge clk);
                pbusy = (phase == 1);
                if (phase == 0) begin
                    if (start) begin phase = 1; ub = 0; end
                end else if (phase == 1) begin
                    if (!stall) begin
                        ub++;
                        if (ub == T) phase = 2;
                    end
                end else begin
                    phase = 0;
                end
                pos = ub % KD;
                t   = ub / KD;
                if (CFG_AO[g] != 0) begin sa = t / SB_N; sb = t % SB_N; end
                else                begin sa = t % SA_N; sb = t / SA_N; end
                exp_rd = (phase == 1) && !(pbusy && stall) && (pos < K);
                exp_td = (phase != 0) && pbusy && !stall && (pos == 0);

                chk($sformatf("c%0d busy", g),      32'(busy),      32'(phase == 1));
                chk($sformatf("c%0d done", g),      32'(done),      32'(phase == 2));
                chk($sformatf("c%0d rd_en", g),     32'(rd_en),     32'(exp_rd));
                chk($sformatf("c%0d first_k", g),   32'(first_k),   32'(exp_rd && pos == 0));
                chk($sformatf("c%0d last_k", g),    32'(last_k),    32'(exp_rd && pos == K - 1));
                chk($sformatf("c%0d tile_done", g), 32'(tile_done), 32'(exp_td));
                if (phase == 1 && pos < K) begin
                    chk($sformatf("c%0d addr_a", g),  32'(addr_a),  32'(sa * K + pos));
                    chk($sformatf("c%0d addr_b", g),  32'(addr_b),  32'(sb * K + pos));
                    chk($sformatf("c%0d k_cntr", g),  32'(k_cntr),  32'(pos));
                    chk($sformatf("c%0d slice_a", g), 32'(slice_a), 32'(sa));
                    chk($sformatf("c%0d slice_b", g), 32'(slice_b), 32'(sb));
                end
                if (phase == 2) n_done++;

                start = (phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
                stall = (cyc >= 200) ? ($urandom_range(0, 5) == 0) : 1'b0;

                if (phase == 1 && cyc >= 300 && $urandom_range(0, 99) < 2) begin
                    #2 rst_n = 1'b0;
                    #1 chk($sformatf("c%0d midrun_reset_zero", g), 32'(any_out()), 32'd0);
                    #1 rst_n = 1'b1;
                    phase = 0; ub = 0;
                    start = 1'b0; stall = 1'b0;
                end
            end
            chk($sformatf("c%0d enough_runs", g), 32'(n_done >= 3), 32'd1);
            n_cfg_done++;
        end
    end

    initial begin
        for (int i = 0; i < 4 * NCYC && n_cfg_done < NCFG; i++) @(posedge clk);
        if (n_cfg_done != NCFG) chk("timeout", 32'(n_cfg_done), 32'(NCFG));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
